// File: rtl/key_cond_pkg.sv
// Shared types and 50 MHz timing constants for the key input conditioner.
package key_cond_pkg;

    localparam int CLK_FREQ_HZ = 50_000_000;
    localparam int CYC_PER_MS  = CLK_FREQ_HZ / 1000;

    localparam int DEBOUNCE_20MS      = 20 * CYC_PER_MS;
    localparam int REPEAT_DELAY_500MS = 500 * CYC_PER_MS;
    localparam int REPEAT_RATE_100MS  = 100 * CYC_PER_MS;

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        HOLD_DELAY  = 2'd1,
        HOLD_REPEAT = 2'd2
    } rpt_state_e;

    // Bits needed to hold max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: synchronizer, debounce, edge pulses, auto-repeat FSM, LED copy.
module key_channel
    import key_cond_pkg::*;
#(
    parameter int ACTIVE_LOW       = 1,
    parameter int DEBOUNCE_CYC     = DEBOUNCE_20MS,
    parameter int REPEAT_DELAY_CYC = REPEAT_DELAY_500MS,
    parameter int REPEAT_RATE_CYC  = REPEAT_RATE_100MS
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    input  logic repeat_en,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_repeat,
    output logic led
);

    localparam int DB_W   = cnt_width(DEBOUNCE_CYC);
    localparam int RP_MAX = ((REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                             REPEAT_DELAY_CYC : REPEAT_RATE_CYC) - 1;
    localparam int RP_W   = cnt_width(RP_MAX);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYC);
    localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE_CYC - 1);
    localparam logic            RAW_IDLE   = (ACTIVE_LOW != 0);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            level_q, level_d;
    logic            led_q, led_d;
    logic            en_q, en_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [RP_W-1:0] rp_cnt_q, rp_cnt_d;
    rpt_state_e      state_q, state_d;
    logic            pressed_s;
    logic            press_s;
    logic            release_s;
    logic            repeat_s;

    assign pressed_s = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
    assign press_s   = level_q & ~led_q;
    assign release_s = ~level_q & led_q;

    always_comb begin
        sync1_d  = key_in;
        sync2_d  = sync1_q;
        led_d    = level_q;
        en_d     = repeat_en;
        level_d  = level_q;
        db_cnt_d = '0;
        // Toggle only after the mismatch has persisted DEBOUNCE_CYC cycles.
        if (pressed_s != level_q) begin
            if (db_cnt_q == DB_LAST) level_d  = ~level_q;
            else                     db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        rp_cnt_d = '0;
        repeat_s = 1'b0;
        case (state_q)
            RELEASED: begin
                if (press_s) begin
                    repeat_s = 1'b1;
                    state_d  = HOLD_DELAY;
                end
            end
            HOLD_DELAY: begin
                if (!level_q) begin
                    state_d = RELEASED;
                end else if (en_q) begin
                    if (rp_cnt_q == DELAY_LAST) begin
                        repeat_s = 1'b1;
                        state_d  = HOLD_REPEAT;
                    end else begin
                        rp_cnt_d = rp_cnt_q + 1'b1;
                    end
                end
            end
            HOLD_REPEAT: begin
                if (!level_q) begin
                    state_d = RELEASED;
                end else if (en_q) begin
                    if (rp_cnt_q == RATE_LAST) repeat_s = 1'b1;
                    else                       rp_cnt_d = rp_cnt_q + 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q  <= RAW_IDLE;
            sync2_q  <= RAW_IDLE;
            level_q  <= 1'b0;
            led_q    <= 1'b0;
            en_q     <= 1'b0;
            db_cnt_q <= '0;
            rp_cnt_q <= '0;
            state_q  <= RELEASED;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            level_q  <= level_d;
            led_q    <= led_d;
            en_q     <= en_d;
            db_cnt_q <= db_cnt_d;
            rp_cnt_q <= rp_cnt_d;
            state_q  <= state_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_s;
    assign key_release = release_s;
    assign key_repeat  = repeat_s;
    assign led         = led_q;

endmodule

// File: rtl/key_input_conditioner.sv
// Array of independent key channels; top level only fans ports out to them.
module key_input_conditioner
    import key_cond_pkg::*;
#(
    parameter int NUM_KEYS         = 5,
    parameter int ACTIVE_LOW       = 1,
    parameter int DEBOUNCE_CYC     = DEBOUNCE_20MS,
    parameter int REPEAT_DELAY_CYC = REPEAT_DELAY_500MS,
    parameter int REPEAT_RATE_CYC  = REPEAT_RATE_100MS
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic [NUM_KEYS-1:0] repeat_en,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic [NUM_KEYS-1:0] led
);

    logic [NUM_KEYS-1:0] level_w, press_w, release_w, repeat_w, led_w;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYC    (DEBOUNCE_CYC),
            .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
            .REPEAT_RATE_CYC (REPEAT_RATE_CYC)
        ) u_ch (
            .sys_clk    (sys_clk),
            .sys_rst    (sys_rst),
            .key_in     (key_in[i]),
            .repeat_en  (repeat_en[i]),
            .key_level  (level_w[i]),
            .key_press  (press_w[i]),
            .key_release(release_w[i]),
            .key_repeat (repeat_w[i]),
            .led        (led_w[i])
        );
    end

    assign key_level   = level_w;
    assign key_press   = press_w;
    assign key_release = release_w;
    assign key_repeat  = repeat_w;
    assign led         = led_w;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner: debounce, glitch, repeat timing, reset.
module tb_key_input_conditioner;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [2:0] key_in;
    logic [2:0] repeat_en;
    logic [2:0] key_level, key_press, key_release, key_repeat, led;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = -1;

    key_input_conditioner #(
        .NUM_KEYS        (3),
        .ACTIVE_LOW      (1),
        .DEBOUNCE_CYC    (4),
        .REPEAT_DELAY_CYC(10),
        .REPEAT_RATE_CYC (3)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .key_in     (key_in),
        .repeat_en  (repeat_en),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_repeat (key_repeat),
        .led        (led)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // cycle n is the interval just after rising edge n of the current scenario
    task automatic tick();
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string tag, input int c,
                       input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, c, obs, exp);
        end
    endtask

    task automatic chk_all(input string scn, input int c,
                           input logic [2:0] lvl, input logic [2:0] prs,
                           input logic [2:0] rel, input logic [2:0] ld);
        chk({scn, "_level"},   c, key_level,   lvl);
        chk({scn, "_press"},   c, key_press,   prs);
        chk({scn, "_release"}, c, key_release, rel);
        chk({scn, "_led"},     c, led,         ld);
    endtask

    initial begin
        sys_rst   = 1'b1;
        key_in    = 3'b111;
        repeat_en = 3'b000;
        repeat (3) tick();
        chk_all("reset", cyc, 3'b000, 3'b000, 3'b000, 3'b000);
        chk("reset_repeat", cyc, key_repeat, 3'b000);
        sys_rst = 1'b0;

        // A: key 0 held with repeat enabled, raw release sampled at edge 20
        repeat_en = 3'b001;
        key_in[0] = 1'b0;
        cyc = -1;
        for (int c = 0; c <= 35; c++) begin
            goto(c);
            chk_all("A", c,
                    {2'b00, (c >= 6 && c < 26)},
                    {2'b00, (c == 6)},
                    {2'b00, (c == 26)},
                    {2'b00, (c >= 7 && c < 27)});
            if (c != 25)
                chk("A_repeat", c, key_repeat,
                    {2'b00, (c == 6 || c == 16 || c == 19 || c == 22)});
            if (c == 19) key_in[0] = 1'b1;
        end

        // B: 3-cycle glitch on key 1 must not disturb anything
        repeat_en = 3'b000;
        key_in[1] = 1'b0;
        cyc = -1;
        for (int c = 0; c <= 15; c++) begin
            goto(c);
            chk_all("B", c, 3'b000, 3'b000, 3'b000, 3'b000);
            chk("B_repeat", c, key_repeat, 3'b000);
            if (c == 2) key_in[1] = 1'b1;
        end

        // C: key 2 held with repeat disabled, then repeat_en raised during cycle 19
        key_in[2] = 1'b0;
        cyc = -1;
        for (int c = 0; c <= 45; c++) begin
            goto(c);
            chk_all("C", c,
                    {(c >= 6 && c < 42), 2'b00},
                    {(c == 6), 2'b00},
                    {(c == 42), 2'b00},
                    {(c >= 7 && c < 43), 2'b00});
            chk("C_repeat", c, key_repeat,
                {(c == 6 || c == 29 || c == 32 || c == 35 || c == 38 || c == 41), 2'b00});
            if (c == 19) repeat_en[2] = 1'b1;
            if (c == 35) key_in[2] = 1'b1;
        end

        // D: keys 0 and 2 together, reset sampled at edge 11 mid-hold
        repeat_en = 3'b000;
        key_in    = 3'b010;
        cyc = -1;
        for (int c = 0; c <= 25; c++) begin
            logic [2:0] lvl, prs, ld;
            goto(c);
            lvl = ((c >= 6 && c <= 10) || c >= 18) ? 3'b101 : 3'b000;
            prs = (c == 6 || c == 18) ? 3'b101 : 3'b000;
            ld  = ((c >= 7 && c <= 10) || c >= 19) ? 3'b101 : 3'b000;
            chk_all("D", c, lvl, prs, 3'b000, ld);
            chk("D_repeat", c, key_repeat, prs);
            if (c == 10) sys_rst = 1'b1;
            if (c == 11) sys_rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
